// File: rtl/icache_line_fill.sv
// -----------------------------------------------------------------------------
// icache_line_fill
// Fills one 32-byte instruction-cache line on a miss: issues a burst read,
// assembles four 64-bit beats into a line buffer, writes the whole line into
// the data array in a single cycle, then pulses fill_done.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   miss_req/addr     fill request and missing byte address (sampled in IDLE)
//   busy              high whenever a fill is in progress
//   fill_done         one-cycle pulse after the array write
//   fill_addr/line    line-aligned address and assembled line of last fill
//   mem_read/addr     burst read request and line-aligned burst address
//   mem_resp/rdata    one 64-bit beat per cycle when mem_resp is high
//   da_csb/addr       data-array chip select (active low) and set index
//   da_wmask/din      data-array byte write mask and write data
//
// state  | meaning
// IDLE   | waiting for miss_req
// REQ    | burst read outstanding, collecting beats 0..3
// WRITE  | line written into the data array (one cycle)
// DONE   | fill_done pulse while the array commits the write (one cycle)
// -----------------------------------------------------------------------------
module icache_line_fill (
    input  logic         clk,
    input  logic         rst,
    input  logic         miss_req,
    input  logic [31:0]  miss_addr,
    output logic         busy,
    output logic         fill_done,
    output logic [31:0]  fill_addr,
    output logic [255:0] fill_line,
    output logic         mem_read,
    output logic [31:0]  mem_addr,
    input  logic         mem_resp,
    input  logic [63:0]  mem_rdata,
    output logic         da_csb,
    output logic [3:0]   da_addr,
    output logic [31:0]  da_wmask,
    output logic [255:0] da_din
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     beat_q, beat_d;
    logic [31:0]    addr_q, addr_d;
    logic [255:0]   line_q, line_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= 2'd0;
            addr_q  <= 32'd0;
            line_q  <= 256'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (miss_req) state_d = S_REQ;
            S_REQ:   if (mem_resp && (beat_q == 2'd3)) state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Line buffer is deliberately not cleared at the start of a new fill;
    // each beat simply overwrites its own 64-bit slot.
    always_comb begin
        beat_d = beat_q;
        addr_d = addr_q;
        line_d = line_q;
        if (state_q == S_IDLE) begin
            if (miss_req) begin
                addr_d = miss_addr & 32'hFFFF_FFE0;
                beat_d = 2'd0;
            end
        end else if (state_q == S_REQ) begin
            if (mem_resp) begin
                line_d[{beat_q, 6'd0} +: 64] = mem_rdata;
                beat_d = beat_q + 2'd1;
            end
        end
    end

    always_comb begin
        busy      = 1'b1;
        fill_done = 1'b0;
        mem_read  = 1'b0;
        da_csb    = 1'b1;
        da_wmask  = 32'd0;
        unique case (state_q)
            S_IDLE:  busy = 1'b0;
            S_REQ:   mem_read = 1'b1;
            S_WRITE: begin
                da_csb   = 1'b0;
                da_wmask = 32'hFFFF_FFFF;
            end
            S_DONE:  fill_done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign fill_addr = addr_q;
    assign mem_addr  = addr_q;
    assign fill_line = line_q;
    assign da_addr   = addr_q[8:5];
    assign da_din    = line_q;

endmodule

// File: tb/tb_icache_line_fill.sv
module tb_icache_line_fill;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         miss_req = 1'b0;
    logic [31:0]  miss_addr = 32'd0;
    logic         mem_resp = 1'b0;
    logic [63:0]  mem_rdata = 64'd0;
    logic         busy, fill_done, mem_read, da_csb;
    logic [31:0]  fill_addr, mem_addr, da_wmask;
    logic [255:0] fill_line, da_din;
    logic [3:0]   da_addr;

    icache_line_fill dut (
        .clk       (clk),
        .rst       (rst),
        .miss_req  (miss_req),
        .miss_addr (miss_addr),
        .busy      (busy),
        .fill_done (fill_done),
        .fill_addr (fill_addr),
        .fill_line (fill_line),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_resp  (mem_resp),
        .mem_rdata (mem_rdata),
        .da_csb    (da_csb),
        .da_addr   (da_addr),
        .da_wmask  (da_wmask),
        .da_din    (da_din)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int wr_cnt = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: a fill is "active" from the accepted request until
    // two edges after the fourth beat has been collected. The first cycle
    // after the fourth beat is the array write, the second is the done pulse.
    bit          m_valid = 1'b0;
    bit          m_active = 1'b0;
    int          m_beats = 0;
    int          m_since = 0;
    logic [31:0] m_addr = 32'd0;
    logic [63:0] m_line [4];

    always @(posedge clk) begin
        if (rst) begin
            m_valid  <= 1'b1;
            m_active <= 1'b0;
            m_beats  <= 0;
            m_since  <= 0;
            m_addr   <= 32'd0;
            for (int i = 0; i < 4; i++) m_line[i] <= 64'd0;
        end else if (!m_active) begin
            if (miss_req) begin
                m_active <= 1'b1;
                m_beats  <= 0;
                m_since  <= 0;
                m_addr   <= {miss_addr[31:5], 5'b00000};
            end
        end else if (m_beats < 4) begin
            if (mem_resp) begin
                m_line[m_beats] <= mem_rdata;
                m_beats <= m_beats + 1;
            end
        end else if (m_since == 1) begin
            m_active <= 1'b0;
        end else begin
            m_since <= m_since + 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic [255:0] e_line;
            logic e_wr, e_done;
            e_line = {m_line[3], m_line[2], m_line[1], m_line[0]};
            e_wr   = m_active && (m_beats == 4) && (m_since == 0);
            e_done = m_active && (m_beats == 4) && (m_since == 1);
            chk("busy", busy, m_active);
            chk("fill_done", fill_done, e_done);
            chk("mem_read", mem_read, m_active && (m_beats < 4));
            chk("mem_addr", mem_addr, m_addr);
            chk("fill_addr", fill_addr, m_addr);
            chk("fill_line", fill_line, e_line);
            chk("da_csb", da_csb, !e_wr);
            chk("da_wmask", da_wmask, e_wr ? 32'hFFFF_FFFF : 32'd0);
            chk("da_addr", da_addr, m_addr[8:5]);
            chk("da_din", da_din, e_line);
            if (fill_done === 1'b1) done_cnt++;
            if (da_csb === 1'b0) wr_cnt++;
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic drive(input logic mr, input logic [31:0] ma, input logic rsp, input logic [63:0] rd);
        miss_req  = mr;
        miss_addr = ma;
        mem_resp  = rsp;
        mem_rdata = rd;
    endtask

    initial begin
        logic [63:0] b [4];
        int d0, w0;

        rst = 1'b1;
        repeat (2) nxt();
        chk("rst_busy", busy, 1'b0);
        chk("rst_fill_done", fill_done, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_da_csb", da_csb, 1'b1);
        chk("rst_da_wmask", da_wmask, 32'd0);
        chk("rst_da_addr", da_addr, 4'd0);
        chk("rst_da_din", da_din, 256'd0);
        chk("rst_fill_line", fill_line, 256'd0);
        chk("rst_fill_addr", fill_addr, 32'd0);
        rst = 1'b0;

        // basic fill, back-to-back beats
        drive(1'b1, 32'h0000_1234, 1'b0, 64'd0);
        chk("t1_idle", busy, 1'b0);
        nxt();
        chk("t1_mem_read", mem_read, 1'b1);
        chk("t1_mem_addr", mem_addr, 32'h0000_1220);
        drive(1'b0, 32'h0, 1'b1, {16{4'h1}});
        nxt(); drive(1'b0, 32'h0, 1'b1, {16{4'h2}});
        nxt(); drive(1'b0, 32'h0, 1'b1, {16{4'h3}});
        nxt(); drive(1'b0, 32'h0, 1'b1, {16{4'h4}});
        nxt(); drive(1'b0, 32'h0, 1'b0, 64'd0);
        chk("t1_wr_csb", da_csb, 1'b0);
        chk("t1_wr_addr", da_addr, 4'h1);
        chk("t1_wr_mask", da_wmask, 32'hFFFF_FFFF);
        chk("t1_wr_din", da_din, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
        chk("t1_mem_read_off", mem_read, 1'b0);
        nxt();
        chk("t1_done", fill_done, 1'b1);
        nxt();
        chk("t1_idle_after", busy, 1'b0);
        chk("t1_line_hold", fill_line, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});

        // gapped beats on cycles 2,5,6,9
        drive(1'b1, 32'hABCD_0040, 1'b0, 64'd0);
        for (int c = 1; c <= 11; c++) begin
            nxt();
            drive(1'b0, 32'h0, (c == 2 || c == 5 || c == 6 || c == 9), {$urandom, $urandom});
            chk($sformatf("t2_mem_read_c%0d", c), mem_read, (c <= 9));
            chk($sformatf("t2_csb_c%0d", c), da_csb, (c != 10));
            chk($sformatf("t2_done_c%0d", c), fill_done, (c == 11));
        end
        nxt(); drive(1'b0, 32'h0, 1'b0, 64'd0);

        // ignored miss_req during REQ, ignored mem_resp in IDLE/DONE
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
        drive(1'b1, 32'h0000_2000, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF);
        for (int c = 1; c <= 4; c++) begin
            nxt(); drive((c == 1 || c == 3), 32'h0000_7000, 1'b1, b[c-1]);
        end
        nxt(); drive(1'b0, 32'h0, 1'b0, 64'd0);
        nxt(); drive(1'b0, 32'h0, 1'b1, 64'hBAD0_BAD0_BAD0_BAD0);
        nxt(); drive(1'b0, 32'h0, 1'b1, 64'hBAD1_BAD1_BAD1_BAD1);
        nxt(); drive(1'b0, 32'h0, 1'b0, 64'd0);
        chk("t3_idle", busy, 1'b0);
        chk("t3_line", fill_line, {b[3], b[2], b[1], b[0]});
        chk("t3_addr", fill_addr, 32'h0000_2000);
        chk("t3_done_count", done_cnt - d0, 1);

        // reset after beat 2, with miss_req asserted alongside reset
        d0 = done_cnt;
        w0 = wr_cnt;
        nxt(); drive(1'b1, 32'h0000_3000, 1'b0, 64'd0);
        nxt(); drive(1'b0, 32'h0, 1'b1, {$urandom, $urandom});
        nxt(); drive(1'b0, 32'h0, 1'b1, {$urandom, $urandom});
        nxt(); drive(1'b1, 32'h0000_3000, 1'b0, 64'd0); rst = 1'b1;
        nxt(); rst = 1'b0;
        chk("t4_busy", busy, 1'b0);
        chk("t4_mem_read", mem_read, 1'b0);
        chk("t4_csb", da_csb, 1'b1);
        chk("t4_line", fill_line, 256'd0);
        chk("t4_addr", fill_addr, 32'd0);
        drive(1'b0, 32'h0, 1'b1, {$urandom, $urandom});
        nxt(); drive(1'b0, 32'h0, 1'b1, {$urandom, $urandom});
        repeat (4) begin nxt(); drive(1'b0, 32'h0, 1'b0, 64'd0); end
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_no_write", wr_cnt - w0, 0);
        chk("t4_line_after", fill_line, 256'd0);

        // set index wrap
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 64'd0);
        nxt(); drive(1'b0, 32'h0, 1'b1, {$urandom, $urandom});
        chk("t5_mem_addr", mem_addr, 32'hFFFF_FFE0);
        repeat (3) begin nxt(); drive(1'b0, 32'h0, 1'b1, {$urandom, $urandom}); end
        nxt(); drive(1'b0, 32'h0, 1'b0, 64'd0);
        chk("t5_da_addr", da_addr, 4'hF);
        chk("t5_csb", da_csb, 1'b0);
        nxt(); nxt();

        // back-to-back fills with miss_req held high
        drive(1'b1, 32'h0000_4100, 1'b0, 64'd0);
        for (int c = 1; c <= 13; c++) begin
            nxt();
            drive(c < 13, 32'h0000_5340, ((c >= 1 && c <= 4) || (c >= 8 && c <= 11)), {$urandom, $urandom});
            if (c == 6)  chk("t6_done1", fill_done, 1'b1);
            if (c == 7) begin
                chk("t6_idle_gap", busy, 1'b0);
                chk("t6_addr_hold", fill_addr, 32'h0000_4100);
            end
            if (c == 8) begin
                chk("t6_second_req", mem_read, 1'b1);
                chk("t6_addr_new", fill_addr, 32'h0000_5340);
            end
            if (c == 12) chk("t6_da_addr", da_addr, 4'hA);
            if (c == 11 || c == 12) chk($sformatf("t6_not_done_c%0d", c), fill_done, 1'b0);
            if (c == 13) chk("t6_done2", fill_done, 1'b1);
        end
        nxt(); drive(1'b0, 32'h0, 1'b0, 64'd0);
        chk("t6_idle_end", busy, 1'b0);

        // randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            nxt();
            rst = ($urandom_range(0, 99) < 2);
            drive(($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 9) < 6), {$urandom, $urandom});
        end
        nxt();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 64'd0);
        repeat (12) nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_line_fill.md
ICACHE_LINE_FILL -- requirements
Module: icache_line_fill

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-002 Ports SHALL be:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- miss_req  in  1  request to fill one line; sampled only in IDLE
- miss_addr  in  32  byte address of missing instruction
- busy  out  1  high whenever state != IDLE
- fill_done  out  1  one-cycle pulse, line written to data array
- fill_addr  out  32  line-aligned address of current/last fill
- fill_line  out  256  assembled line buffer
- mem_read  out  1  burst read request to memory
- mem_addr  out  32  line-aligned burst address
- mem_resp  in  1  one 64-bit beat valid this cycle
- mem_rdata  in  64  beat data
- da_csb  out  1  data-array write chip select, active low
- da_addr  out  4  data-array set index
- da_wmask  out  32  data-array byte write mask
- da_din  out  256  data-array write data

Function
REQ-003 Address split SHALL be offset [4:0], set [8:5], tag [31:9]; fill_addr = mem_addr = {miss_addr[31:5], 5'b0}.
REQ-004 FSM states SHALL be IDLE, REQ, WRITE, DONE.
REQ-005 IDLE: on miss_req=1, latch line-aligned address, clear beat counter, go to REQ next cycle; else stay.
REQ-006 REQ: mem_read=1 and mem_addr held constant every cycle until the 4th beat is accepted.
REQ-007 Each cycle in REQ with mem_resp=1, mem_rdata SHALL be stored to fill_line[64*i+63:64*i], i = 2-bit beat counter, then counter increments.
REQ-008 The edge accepting beat 3 SHALL move to WRITE; mem_read SHALL be 0 from the WRITE cycle on.
REQ-009 WRITE (exactly one cycle): da_csb=0, da_addr=fill_addr[8:5], da_wmask=32'hFFFF_FFFF, da_din=fill_line; next state DONE.
REQ-010 Outside WRITE: da_csb=1, da_wmask=0; da_addr/da_din don't-care but SHALL equal fill_addr[8:5]/fill_line.
REQ-011 DONE (exactly one cycle): fill_done=1, covering the array's one-cycle internal write commit; next state IDLE.
REQ-012 Latency with back-to-back beats: miss_req at cycle 0 -> REQ at 1 -> beats at 1..4 -> WRITE at 5 -> fill_done at 6; otherwise DONE = last-beat cycle + 2.
REQ-013 miss_req outside IDLE SHALL be ignored; no queueing.
REQ-014 mem_resp outside REQ SHALL be ignored; fill_line unchanged.
REQ-015 mem_resp gaps in REQ SHALL stall the counter without error.
REQ-016 fill_line and fill_addr SHALL hold after DONE until the next accepted miss_req; fill_line is not cleared at new fill start.
REQ-017 busy SHALL be combinational from state: 0 in IDLE, 1 in REQ/WRITE/DONE.

Reset
REQ-018 rst=1 at a rising edge SHALL force IDLE, beat counter=0, fill_addr=0, fill_line=0 next cycle.
REQ-019 Reset values: busy=0, fill_done=0, mem_read=0, mem_addr=0, da_csb=1, da_wmask=0, da_addr=0, da_din=0.
REQ-020 Reset mid-fill (REQ/WRITE/DONE) SHALL abort: no da_csb=0, no fill_done; later beats ignored.
REQ-021 rst SHALL override miss_req in the same cycle.

Verification
REQ-022 Basic fill: miss_addr=32'h0000_1234, beats 64'h11..11,22..22,33..33,44..44 on consecutive cycles -> mem_addr=32'h0000_1220; WRITE cycle da_addr=4'h1, da_wmask=all ones, da_din={44..,33..,22..,11..}; fill_done next cycle.
REQ-023 Gapped beats: mem_resp=1 only on cycles 2,5,6,9 -> mem_read high through cycle 9; WRITE at 10; fill_done at 11.
REQ-024 Ignored inputs: miss_req pulses during REQ and mem_resp during IDLE/DONE -> no second fill, fill_line unchanged, one fill_done.
REQ-025 Reset mid-fill: rst after beat 2 -> next cycle IDLE, mem_read=0, da_csb=1; beats 3-4 then arriving -> no write, no fill_done.
REQ-026 Set wrap: miss_addr=32'hFFFF_FFFC -> mem_addr=32'hFFFF_FFE0, da_addr=4'hF.
REQ-027 Back-to-back: miss_req held high -> second fill accepted in the IDLE cycle after DONE; fill_addr updates then; second fill_done exactly after its own 4 beats.
